div_sequencer: RTL and testbench

- Multi-cycle controller for the Mini SRC DIV instruction.
- Runs a radix-2 non-restoring signed division, one quotient bit per clock, behind a start/busy/done handshake.
- Holds the result in HI (remainder) and LO (quotient) output registers until the next operation completes.
- Sits between the control unit (which issues start and stalls on busy) and the HI/LO register write path.

---
 rtl/div_sequencer.sv | 173 +++++++++++++++++
 tb/tb_div_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 non-restoring signed divider for the Mini SRC DIV instruction.
// Optional macro DIV_SEQUENCER_EARLY_OUT_EN: skip iteration when |divisor| > |dividend|.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSetup   = 3'd1;
  localparam logic [2:0] StIter    = 3'd2;
  localparam logic [2:0] StCorrect = 3'd3;
  localparam logic [2:0] StSign    = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   mag_q, mag_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   acc_sh, acc_iter;

  assign sign_a = a_q[WIDTH-1];
  assign sign_b = b_q[WIDTH-1];

  // Unsigned WIDTH-bit magnitudes; the most negative value maps to 2^(WIDTH-1) exactly.
  assign mag_a = sign_a ? (WIDTH'(0) - a_q) : a_q;
  assign mag_b = sign_b ? (WIDTH'(0) - b_q) : b_q;

  assign acc_sh   = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign acc_iter = acc_q[WIDTH] ? (acc_sh + mag_q) : (acc_sh - mag_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        acc_d = '0;
        quo_d = mag_a;
        mag_d = {1'b0, mag_b};
        cnt_d = '0;
        if (b_q == '0) begin
          lo_d    = '1;
          hi_d    = a_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
        else if (mag_b > mag_a) begin
          lo_d    = '0;
          hi_d    = a_q;
          done_d  = 1'b1;
          state_d = StDone;
        end
`endif
        else begin
          state_d = StIter;
        end
      end
      StIter: begin
        acc_d = acc_iter;
        quo_d = {quo_q[WIDTH-2:0], ~acc_iter[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StCorrect;
        end
      end
      StCorrect: begin
        // Only the remainder needs restoring; the quotient bits are already exact.
        if (acc_q[WIDTH]) begin
          acc_d = acc_q + mag_q;
        end
        state_d = StSign;
      end
      StSign: begin
        lo_d    = (sign_a ^ sign_b) ? (WIDTH'(0) - quo_q) : quo_q;
        hi_d    = sign_a ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed table, corner sequences, random vs. model.
module tb_div_sequencer;

  localparam int W = 32;
  localparam int LatFull = W + 3;
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif
  localparam int LatSmall = EarlyOut ? 1 : LatFull;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  div_sequencer #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: plain wide signed arithmetic, truncating division.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dbz, output int lat);
    longint sa, sb, q, r, ma, mb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      lo = '1;
      hi = a;
      dbz = 1'b1;
      lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
      dbz = 1'b0;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      lat = (EarlyOut && (mb > ma)) ? 1 : LatFull;
    end
  endfunction

  // One operation: pulse start, count edges until done, optionally pulse a stray start.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch_at,
                        output logic [W-1:0] lo, output logic [W-1:0] hi,
                        output logic dbz, output int lat);
    logic [W-1:0] hold_hi, hold_lo;
    logic stray;
    @(negedge clock);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check1("busy_on_accept", busy, 1'b1);
    check1("dbz_cleared_on_accept", div_by_zero, 1'b0);
    hold_hi = hi_out;
    hold_lo = lo_out;
    stray = 1'b0;
    lat = 0;
    while (lat < 100 && !done) begin
      if (glitch_at == lat + 1) begin
        start = 1'b1;
        dividend = ~a;
        divisor = b + 1;
      end
      @(posedge clock);
      #1;
      lat++;
      start = 1'b0;
      if (!busy) stray = 1'b1;
      if (!done && (hi_out !== hold_hi || lo_out !== hold_lo)) stray = 1'b1;
    end
    check1("busy_high_outputs_held", stray, 1'b0);
    lo = lo_out;
    hi = hi_out;
    dbz = div_by_zero;
    @(posedge clock);
    #1;
    check1("done_one_cycle", done, 1'b0);
    check1("busy_release", busy, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[10];
  logic [W-1:0] got_lo, got_hi, exp_lo, exp_hi, ra, rb;
  logic got_dbz, exp_dbz, seen;
  int got_lat, exp_lat;

  initial begin
    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LatFull};
    vecs[1] = '{-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LatFull};
    vecs[2] = '{32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, LatFull};
    vecs[3] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1};
    vecs[4] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LatFull};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LatFull};
    vecs[6] = '{32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, LatFull};
    vecs[7] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0, LatSmall};
    vecs[8] = '{-32'sd7, 32'd100, 32'd0, 32'hFFFF_FFF9, 1'b0, LatSmall};
    vecs[9] = '{32'd7, 32'd7, 32'd1, 32'd0, 1'b0, LatFull};

    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_dbz", div_by_zero, 1'b0);
    check("reset_hi", hi_out, '0);
    check("reset_lo", lo_out, '0);
    @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, got_lo, got_hi, got_dbz, got_lat);
      check($sformatf("vec%0d_lo", i), got_lo, vecs[i].lo);
      check($sformatf("vec%0d_hi", i), got_hi, vecs[i].hi);
      check1($sformatf("vec%0d_dbz", i), got_dbz, vecs[i].dbz);
      check($sformatf("vec%0d_latency", i), got_lat, vecs[i].lat);
    end

    // Stray start during iteration must neither disturb nor queue.
    run_op(32'd100, 32'd7, 6, got_lo, got_hi, got_dbz, got_lat);
    check("glitch_lo", got_lo, 32'd14);
    check("glitch_hi", got_hi, 32'd2);
    check("glitch_latency", got_lat, LatFull);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (busy || done) seen = 1'b1;
    end
    check1("glitch_not_queued", seen, 1'b0);

    // Reset on the 10th iteration edge (edge k+11) aborts without a result.
    @(negedge clock);
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check("abort_hi", hi_out, '0);
    check("abort_lo", lo_out, '0);
    @(negedge clock);
    clear = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (busy || done || hi_out != '0 || lo_out != '0) seen = 1'b1;
    end
    check1("abort_no_result", seen, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1: begin
          ra = $urandom;
          rb = W'($signed($urandom_range(0, 31)) - 16);
        end
        2: begin
          ra = W'($signed($urandom_range(0, 2000)) - 1000);
          rb = W'($signed($urandom_range(0, 2000)) - 1000);
        end
        default: begin
          ra = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : $urandom;
          rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
        end
      endcase
      ref_div(ra, rb, exp_lo, exp_hi, exp_dbz, exp_lat);
      run_op(ra, rb, 0, got_lo, got_hi, got_dbz, got_lat);
      check($sformatf("rand%0d_lo a=%h b=%h", i, ra, rb), got_lo, exp_lo);
      check($sformatf("rand%0d_hi a=%h b=%h", i, ra, rb), got_hi, exp_hi);
      check1($sformatf("rand%0d_dbz", i), got_dbz, exp_dbz);
      check($sformatf("rand%0d_latency", i), got_lat, exp_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
